// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: size codes, port indices,
// FSM state and the registered read tag.
package dmem_pkg;
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int PORT_CORE = 0;
  localparam int PORT_DMA  = 1;

  typedef enum logic {ARB, LOCKED} arb_state_t;

  typedef struct packed {
    logic vld;
    logic port;
  } rd_tag_t;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-winner register; masked ports
// never win, so the caller can exclude a requester for a cycle.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);
  logic [1:0] elig;
  logic       last;

  always_comb begin
    elig = req & ~mask;
    if (elig == 2'b11) gnt = last ? 2'b01 : 2'b10;
    else               gnt = elig;
  end

  // Reset to DMA so the core wins the first contention.
  always_ff @(posedge clk) begin
    if (rst)       last <= 1'(PORT_DMA);
    else if (|gnt) last <= gnt[1];
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the core LSU (port 0) and
// the DMA/loader (port 1), with an optional bounded DMA lock.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_i,
  input  logic [1:0]             we_i,
  input  logic [1:0][ADDR_W-1:0] addr_i,
  input  logic [1:0][2:0]        size_i,
  input  logic [1:0][31:0]       wdata_i,
  input  logic                   lock_i,
  output logic [1:0]             gnt_o,
  output logic [1:0]             rvalid_o,
  output logic [31:0]            rdata_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic [2:0]             mem_size_o,
  output logic [31:0]            mem_wdata_o,
  output logic                   mem_wen_o,
  input  logic [31:0]            mem_rdata_i
);
  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_t    state;
  logic [CW-1:0] lock_cnt;
  rd_tag_t       tag;
  logic [1:0]    mask;
  logic          gp;

  // Reset masks both ports so every output sits at its idle value.
  assign mask = {rst, rst | (state == LOCKED)};

  rr_arb2 u_rr (
    .clk  (clk),
    .rst  (rst),
    .req  (req_i),
    .mask (mask),
    .gnt  (gnt_o)
  );

  assign gp = gnt_o[1];

  always_comb begin
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_size_o  = SZ_W;
    mem_wdata_o = '0;
    if (|gnt_o) begin
      mem_wen_o   = we_i[gp];
      mem_addr_o  = addr_i[gp];
      mem_size_o  = size_i[gp];
      mem_wdata_o = wdata_i[gp];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      lock_cnt <= '0;
      tag      <= '0;
    end else begin
      tag.vld  <= (|gnt_o) & ~we_i[gp];
      tag.port <= gp;
      case (state)
        ARB: begin
          if (gnt_o[1] && lock_i && LOCK_MAX > 1) begin
            state    <= LOCKED;
            lock_cnt <= CW'(1);
          end
        end
        LOCKED: begin
          // Exit is registered: the cycle that reaches the limit or sees
          // lock_i low is still exclusive; arbitration resumes next cycle.
          if (!lock_i || lock_cnt == CW'(LOCK_MAX - 1)) begin
            state    <= ARB;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + CW'(1);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign rvalid_o = (tag.vld && !rst) ? (tag.port ? 2'b10 : 2'b01) : 2'b00;
  assign rdata_o  = (tag.vld && !rst) ? mem_rdata_i : 32'h0;
endmodule
